// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle core front end:
// sequencer states, one-hot phase codes, bubble word and HLT decode.
package core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALTED,
        ST_ERROR
    } state_t;

    localparam logic [4:0] PH_NONE = 5'b00000;
    localparam logic [4:0] P1      = 5'b00001;
    localparam logic [4:0] P2      = 5'b00010;
    localparam logic [4:0] P3      = 5'b00100;
    localparam logic [4:0] P4      = 5'b01000;
    localparam logic [4:0] P5      = 5'b10000;

    // Decodes to all switches off and writeOrder 0, so the datapath idles.
    localparam logic [15:0] BUBBLE_OP_DEFAULT = 16'hC0E0;

    localparam logic [1:0] OPCLASS_ALU = 2'b11;
    localparam logic [3:0] FUNCT_HLT   = 4'b1111;

    function automatic logic is_hlt(input logic [15:0] word);
        return (word[15:14] == OPCLASS_ALU) && (word[7:4] == FUNCT_HLT);
    endfunction

endpackage

// File: rtl/instruction_fetch_sequencer_if.sv
// Instruction memory req/ack bus between the fetch sequencer (master)
// and instruction memory (slave).
interface instruction_fetch_sequencer_if;

    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_timeout_counter.sv
// 8-bit wait counter for the fetch handshake; tc marks the cycle whose
// increment brings the count up to TERMINAL.
module fetch_timeout_counter #(
    parameter logic [7:0] TERMINAL = 8'd255
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [7:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (clr) begin
            count <= 8'd0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    assign tc = en && (count == (TERMINAL - 8'd1));

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Front end of the 16-bit multi-cycle core: holds the PC, fetches over req/ack,
// latches the instruction register and walks the five one-hot phases.
module instruction_fetch_sequencer
    import core_pkg::*;
#(
    parameter logic [15:0] RESET_PC      = 16'h0000,
    parameter logic [7:0]  FETCH_TIMEOUT = 8'd255,
    parameter logic [15:0] BUBBLE_OP     = BUBBLE_OP_DEFAULT
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 run,
    instruction_fetch_sequencer_if.master        imem,
    output logic [15:0]                          op,
    output logic [4:0]                           phase,
    output logic [15:0]                          pc_next,
    input  logic                                 branch_taken,
    input  logic [15:0]                          branch_target,
    output logic                                 wb_phase,
    output logic                                 halted,
    output logic                                 fetch_err
);

    state_t      state;
    logic [15:0] pc;
    logic        req_q;
    logic        cnt_clr;
    logic        cnt_en;
    logic        fetch_tc;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;
    assign wb_phase       = phase[4];

    // Count only the FETCH cycles that go by without an ack.
    assign cnt_clr = (state != ST_FETCH) || imem.imem_ack;
    assign cnt_en  = (state == ST_FETCH) && !imem.imem_ack;

    fetch_timeout_counter #(
        .TERMINAL (FETCH_TIMEOUT)
    ) u_timeout (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (fetch_tc)
    );

    // pc_next is pc+1 while pc still addresses the word being fetched,
    // and equals pc once the fetch has advanced it (DECODE onward).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            pc_next   <= RESET_PC + 16'd1;
            op        <= BUBBLE_OP;
            phase     <= PH_NONE;
            req_q     <= 1'b0;
            halted    <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state <= ST_FETCH;
                        phase <= P1;
                        req_q <= 1'b1;
                    end
                end

                ST_FETCH: begin
                    if (imem.imem_ack) begin
                        op      <= imem.imem_rdata;
                        pc      <= pc + 16'd1;
                        pc_next <= pc + 16'd1;
                        req_q   <= 1'b0;
                        phase   <= P2;
                        state   <= ST_DECODE;
                    end else if (fetch_tc) begin
                        fetch_err <= 1'b1;
                        req_q     <= 1'b0;
                        op        <= BUBBLE_OP;
                        phase     <= PH_NONE;
                        state     <= ST_ERROR;
                    end
                end

                ST_DECODE: begin
                    if (is_hlt(op)) begin
                        halted <= 1'b1;
                        phase  <= PH_NONE;
                        state  <= ST_HALTED;
                    end else begin
                        phase <= P3;
                        state <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    phase <= P4;
                    state <= ST_MEM;
                end

                ST_MEM: begin
                    phase <= P5;
                    state <= ST_WB;
                end

                ST_WB: begin
                    if (branch_taken) begin
                        pc      <= branch_target;
                        pc_next <= branch_target + 16'd1;
                    end else begin
                        pc_next <= pc + 16'd1;
                    end
                    phase <= P1;
                    req_q <= 1'b1;
                    state <= ST_FETCH;
                end

                ST_HALTED: begin
                    // Resume at the word after HLT; pc already points there.
                    if (run) begin
                        halted  <= 1'b0;
                        pc_next <= pc + 16'd1;
                        phase   <= P1;
                        req_q   <= 1'b1;
                        state   <= ST_FETCH;
                    end
                end

                ST_ERROR: begin
                    phase <= PH_NONE;
                    req_q <= 1'b0;
                end

                default: begin
                    phase <= PH_NONE;
                    req_q <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Bench for instruction_fetch_sequencer: memory responder feeds a scoreboard of
// fetched words that is checked whenever the sequencer reaches DECODE.
module tb_instruction_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] op;
    logic [4:0]  phase;
    logic [15:0] pc_next;
    logic        wb_phase;
    logic        halted;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:65535];
    logic [15:0] exp_op [$];
    logic [15:0] exp_word;
    bit          mem_en = 1'b1;
    int          ack_delay = 0;
    bit          stray_ack = 1'b0;
    int          wait_cnt = 0;

    instruction_fetch_sequencer_if imem ();

    instruction_fetch_sequencer #(
        .RESET_PC      (16'h0000),
        .FETCH_TIMEOUT (8'd255),
        .BUBBLE_OP     (16'hC0E0)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .run           (run),
        .imem          (imem),
        .op            (op),
        .phase         (phase),
        .pc_next       (pc_next),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .wb_phase      (wb_phase),
        .halted        (halted),
        .fetch_err     (fetch_err)
    );

    always #5 clock = ~clock;

    // Memory: acks after ack_delay wait cycles, records each word it returns.
    initial begin
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        forever begin
            @(negedge clock);
            if (imem.imem_ack) begin
                imem.imem_ack = 1'b0;
            end else if (stray_ack) begin
                imem.imem_ack   = 1'b1;
                imem.imem_rdata = 16'hDEAD;
                stray_ack       = 1'b0;
            end else if (mem_en && imem.imem_req) begin
                if (wait_cnt >= ack_delay) begin
                    imem.imem_ack   = 1'b1;
                    imem.imem_rdata = mem[imem.imem_addr];
                    exp_op.push_back(mem[imem.imem_addr]);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Every DECODE cycle must present the oldest word memory handed over.
    initial begin
        forever begin
            @(negedge clock);
            if (reset === 1'b0 && phase === 5'b00010) begin
                checks++;
                if (exp_op.size() == 0) begin
                    errors++;
                    $display("FAIL decode_op: op=%h in DECODE with no word fetched", op);
                end else begin
                    exp_word = exp_op.pop_front();
                    if (op !== exp_word) begin
                        errors++;
                        $display("FAIL decode_op: got %h want %h", op, exp_word);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(negedge clock);
        #1;
        reset         = 1'b1;
        run           = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        mem_en        = 1'b1;
        ack_delay     = 0;
        stray_ack     = 1'b0;
        exp_op.delete();
        repeat (2) @(negedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic pulse_run();
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
    endtask

    task automatic wait_phase(input logic [4:0] p, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (phase === p) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (phase !== 5'b00000) begin errors++; $display("FAIL reset_phase: got %b want 00000", phase); end
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem.imem_req); end
        checks++; if (op !== 16'hC0E0) begin errors++; $display("FAIL reset_op: got %h want c0e0", op); end
        checks++; if (imem.imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want 0000", imem.imem_addr); end
        checks++; if (pc_next !== 16'h0001) begin errors++; $display("FAIL reset_pc_next: got %h want 0001", pc_next); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_fetch_err: got %b want 0", fetch_err); end
    endtask

    task automatic test_basic();
        logic [4:0] seq [0:5];
        seq = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        do_reset();
        mem[0] = 16'h1234;
        mem[1] = 16'h2000;
        pulse_run();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (phase !== seq[i]) begin errors++; $display("FAIL basic_phase%0d: got %b want %b", i, phase, seq[i]); end
            if (i == 0) begin
                checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 16'h0000) begin
                    errors++; $display("FAIL basic_fetch0: req %b addr %h want 1 0000", imem.imem_req, imem.imem_addr); end
            end
            if (i == 1) begin
                checks++; if (op !== 16'h1234) begin errors++; $display("FAIL basic_op: got %h want 1234", op); end
                checks++; if (pc_next !== 16'h0001) begin errors++; $display("FAIL basic_pc_next: got %h want 0001", pc_next); end
            end
            if (i == 2) run = 1'b1;
            if (i == 3) run = 1'b0;
            if (i == 4) begin
                checks++; if (wb_phase !== 1'b1) begin errors++; $display("FAIL basic_wb_phase: got %b want 1", wb_phase); end
            end
            if (i == 5) begin
                checks++; if (imem.imem_addr !== 16'h0001) begin errors++; $display("FAIL basic_next_addr: got %h want 0001", imem.imem_addr); end
            end
            @(negedge clock);
        end
    endtask

    task automatic test_delay();
        int  req_cycles;
        int  period;
        bit  addr_ok;
        req_cycles = 0;
        period     = 0;
        addr_ok    = 1'b1;
        do_reset();
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        ack_delay = 3;
        pulse_run();
        while (imem.imem_req === 1'b1 && req_cycles < 20) begin
            if (imem.imem_addr !== 16'h0000) addr_ok = 1'b0;
            req_cycles++;
            period++;
            @(negedge clock);
        end
        checks++; if (req_cycles !== 4) begin errors++; $display("FAIL delay_req_cycles: got %0d want 4", req_cycles); end
        checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL delay_addr_stable: got %b want 1", addr_ok); end
        while (phase !== 5'b00001 && period < 30) begin
            period++;
            @(negedge clock);
        end
        checks++; if (period !== 8) begin errors++; $display("FAIL delay_period: got %0d want 8", period); end
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL delay_fetch_err: got %b want 0", fetch_err); end
    endtask

    task automatic test_branch();
        bit ok;
        do_reset();
        mem[16'h0040] = 16'h4040;
        mem[16'h0041] = 16'h4141;
        pulse_run();
        wait_phase(5'b10000, 10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL branch_wait_wb: got no WB want WB"); end
        branch_taken  = 1'b1;
        branch_target = 16'h0040;
        @(negedge clock);
        branch_taken = 1'b0;
        checks++; if (phase !== 5'b00001 || imem.imem_addr !== 16'h0040) begin
            errors++; $display("FAIL branch_wb_target: phase %b addr %h want 00001 0040", phase, imem.imem_addr); end
        wait_phase(5'b00010, 10, ok);
        checks++; if (pc_next !== 16'h0041) begin errors++; $display("FAIL branch_pc_next: got %h want 0041", pc_next); end
        @(negedge clock);
        checks++; if (phase !== 5'b00100) begin errors++; $display("FAIL branch_exec: got %b want 00100", phase); end
        branch_taken  = 1'b1;
        branch_target = 16'h0099;
        @(negedge clock);
        branch_taken = 1'b0;
        wait_phase(5'b00001, 10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL branch_wait_fetch: got no FETCH want FETCH"); end
        checks++; if (imem.imem_addr !== 16'h0041) begin errors++; $display("FAIL branch_exec_ignored: got %h want 0041", imem.imem_addr); end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        mem[16'hFFFF] = 16'h3456;
        pulse_run();
        wait_phase(5'b10000, 10, ok);
        branch_taken  = 1'b1;
        branch_target = 16'hFFFF;
        @(negedge clock);
        branch_taken = 1'b0;
        checks++; if (imem.imem_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_fetch_ffff: got %h want ffff", imem.imem_addr); end
        wait_phase(5'b00010, 10, ok);
        checks++; if (op !== 16'h3456) begin errors++; $display("FAIL wrap_op: got %h want 3456", op); end
        checks++; if (pc_next !== 16'h0000) begin errors++; $display("FAIL wrap_pc_next: got %h want 0000", pc_next); end
        @(negedge clock);
        wait_phase(5'b00001, 10, ok);
        checks++; if (!ok || imem.imem_addr !== 16'h0000) begin
            errors++; $display("FAIL wrap_next_addr: got %h want 0000", imem.imem_addr); end
    endtask

    task automatic test_halt();
        int steps;
        bit ok;
        steps = 0;
        do_reset();
        mem[0] = 16'h0001;
        mem[1] = 16'hC0F0;
        mem[2] = 16'h5555;
        pulse_run();
        while (halted !== 1'b1 && steps < 20) begin
            steps++;
            @(negedge clock);
        end
        checks++; if (steps !== 7) begin errors++; $display("FAIL halt_latency: got %0d want 7", steps); end
        checks++; if (phase !== 5'b00000) begin errors++; $display("FAIL halt_phase: got %b want 00000", phase); end
        checks++; if (op !== 16'hC0F0) begin errors++; $display("FAIL halt_op: got %h want c0f0", op); end
        checks++; if (pc_next !== 16'h0002) begin errors++; $display("FAIL halt_pc_next: got %h want 0002", pc_next); end
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL halt_req: got %b want 0", imem.imem_req); end
        repeat (3) @(negedge clock);
        checks++; if (halted !== 1'b1 || phase !== 5'b00000) begin
            errors++; $display("FAIL halt_hold: halted %b phase %b want 1 00000", halted, phase); end
        pulse_run();
        checks++; if (phase !== 5'b00001 || imem.imem_addr !== 16'h0002 || halted !== 1'b0) begin
            errors++; $display("FAIL halt_resume: phase %b addr %h halted %b want 00001 0002 0", phase, imem.imem_addr, halted); end
        wait_phase(5'b00010, 10, ok);
        checks++; if (!ok || op !== 16'h5555) begin errors++; $display("FAIL halt_resume_op: got %h want 5555", op); end
    endtask

    task automatic test_timeout();
        int req_cycles;
        req_cycles = 0;
        do_reset();
        mem_en = 1'b0;
        pulse_run();
        while (fetch_err !== 1'b1 && req_cycles < 400) begin
            if (imem.imem_req === 1'b1) req_cycles++;
            @(negedge clock);
        end
        checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", fetch_err); end
        checks++; if (req_cycles !== 255) begin errors++; $display("FAIL timeout_req_cycles: got %0d want 255", req_cycles); end
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL timeout_req: got %b want 0", imem.imem_req); end
        checks++; if (op !== 16'hC0E0) begin errors++; $display("FAIL timeout_op: got %h want c0e0", op); end
        checks++; if (phase !== 5'b00000) begin errors++; $display("FAIL timeout_phase: got %b want 00000", phase); end
        pulse_run();
        repeat (2) @(negedge clock);
        checks++; if (phase !== 5'b00000 || imem.imem_req !== 1'b0) begin
            errors++; $display("FAIL timeout_run_ignored: phase %b req %b want 00000 0", phase, imem.imem_req); end
        checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", fetch_err); end
        mem_en = 1'b1;
    endtask

    task automatic test_reset_midfetch();
        do_reset();
        ack_delay = 10;
        pulse_run();
        @(negedge clock);
        checks++; if (imem.imem_req !== 1'b1) begin errors++; $display("FAIL midfetch_req: got %b want 1", imem.imem_req); end
        #2 reset = 1'b1;
        #1;
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL midfetch_async_req: got %b want 0", imem.imem_req); end
        checks++; if (phase !== 5'b00000) begin errors++; $display("FAIL midfetch_async_phase: got %b want 00000", phase); end
        checks++; if (op !== 16'hC0E0) begin errors++; $display("FAIL midfetch_async_op: got %h want c0e0", op); end
        stray_ack = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (phase !== 5'b00000) begin errors++; $display("FAIL late_ack_phase: got %b want 00000", phase); end
        checks++; if (op !== 16'hC0E0) begin errors++; $display("FAIL late_ack_op: got %h want c0e0", op); end
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL late_ack_req: got %b want 0", imem.imem_req); end
        checks++; if (imem.imem_addr !== 16'h0000 || pc_next !== 16'h0001) begin
            errors++; $display("FAIL late_ack_pc: addr %h pc_next %h want 0000 0001", imem.imem_addr, pc_next); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_delay();
        test_branch();
        test_wrap();
        test_halt();
        test_timeout();
        test_reset_midfetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_sequencer.md
Name: instruction_fetch_sequencer

Overview:
Front end of the multi-cycle 16-bit core. Holds the PC and fetches each instruction from instruction memory over a req/ack handshake. Latches the instruction into an instruction register whose output `op` feeds the data selecter controller and decoder. Drives a one-hot five-phase sequence (P1 fetch, P2 decode/read, P3 execute, P4 memory, P5 writeback), applies branch redirects, and stops on HLT.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
FETCH_TIMEOUT, 255, max cycles waiting for imem_ack before fetch_err is raised; 8-bit counter.
BUBBLE_OP, 16'hC0E0, op value driven when no valid instruction is held; decodes to all switches 0, writeOrder 0.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
run  in  1  start pulse; honoured only in IDLE or HALTED.
imem_req  out  1  fetch request; held high until ack.
imem_addr  out  16  fetch address (= pc), stable while imem_req is high.
imem_ack  in  1  memory has placed valid data on imem_rdata this cycle.
imem_rdata  in  16  instruction word.
op  out  16  instruction register contents to the decoder.
phase  out  5  one-hot phase; bit0 = P1 … bit4 = P5; 0 when not running.
pc_next  out  16  address of the following instruction (link value for BAL writeback).
branch_taken  in  1  redirect request; sampled only during P5.
branch_target  in  16  redirect address; sampled with branch_taken.
wb_phase  out  1  = phase[4]; the register file ANDs this with writeOrder.
halted  out  1  high in HALTED.
fetch_err  out  1  sticky; set on fetch timeout; cleared by reset only.

Behaviour:
- Reset (async, any state): state=IDLE, pc=RESET_PC, op=BUBBLE_OP, phase=0, imem_req=0, halted=0, fetch_err=0, timeout counter=0, pc_next=RESET_PC+1. An outstanding fetch is abandoned; an ack arriving after reset deasserts is ignored.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED, ERROR.
- IDLE: run=1 -> FETCH next cycle.
- FETCH (phase=00001):
  - imem_req=1, imem_addr=pc.
  - On imem_ack: op<=imem_rdata, pc<=pc+1 (16-bit wrap, 16'hFFFF -> 16'h0000), counter<=0, -> DECODE.
  - Without ack, counter increments. When counter reaches FETCH_TIMEOUT with no ack: fetch_err<=1, imem_req drops, op<=BUBBLE_OP, -> ERROR.
  - Minimum fetch latency is one cycle (ack in the first req cycle).
- DECODE (00010): if op[15:14]=2'b11 and op[7:4]=4'b1111 (HLT) -> HALTED; otherwise -> EXEC.
- EXEC (00100) -> MEM (01000) -> WB (10000): one cycle each, unconditional.
- WB: if branch_taken, pc<=branch_target, else pc is unchanged. Then -> FETCH.
- Instruction period is 5 cycles plus extra ack wait cycles.
- branch_taken outside WB is ignored.
- pc_next = pc, which already points past the current instruction from DECODE onward. It is the required link value for BAL.
- HALTED: phase=0, halted=1, op holds the HLT word. run=1 -> FETCH at the current pc, the instruction after HLT.
- ERROR: terminal until reset; run ignored; phase=0.
- run while running or in ERROR: no effect.

Decomposition:
- Shared package core_pkg:
  - state enum.
  - Phase one-hot constants P1..P5.
  - BUBBLE_OP.
  - HLT match constants: OPCLASS_ALU=2'b11, FUNCT_HLT=4'b1111.
- Natural sub-module: fetch_timeout_counter (8-bit counter with clear, enable, and terminal-count output).
- All else lives in one FSM module.

Test Plan:
- Reset then run; memory acks on the first req cycle with 16'h1234 at addr 0 -> op=16'h1234 in DECODE; phase walks 00001, 00010, 00100, 01000, 10000 over 5 cycles; next fetch address 1; pc_next=1.
- Ack delayed 3 cycles -> imem_req high for 4 cycles with imem_addr stable; period = 8 cycles; fetch_err=0.
- branch_taken=1 with target 16'h0040 in WB -> next imem_addr=16'h0040. The same pulse in EXEC has no effect: next addr = pc+1.
- pc=16'hFFFF fetch -> next fetch address 16'h0000.
- HLT word 16'hC0F0 fetched -> halted=1 after DECODE, phase=0. run -> fetch resumes at HLT address + 1.
- No ack for 255 cycles -> fetch_err=1, imem_req=0, op=16'hC0E0; run ignored. Async reset mid-FETCH -> immediate IDLE; late ack ignored.
